// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, addresses a one-cycle-latency instruction
// memory and hands each instruction to the decoder with start/halt/stall/branch control.
module instr_fetch #(
    parameter int                 PC_W      = 10,
    parameter int                 INSTR_W   = 9,
    parameter int                 START_PC  = 0,
    parameter logic [INSTR_W-1:0] HALT_CODE = 9'b111_111_111,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [2:0]         opcode,
    output logic               last_bit,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               done,
    output logic [CNT_W-1:0]   instr_count
);

    localparam logic [PC_W-1:0] START_ADDR = PC_W'(START_PC);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetchState_e;

    fetchState_e      stateReg, stateNext;
    logic [PC_W-1:0]  pcReg, pcNext;
    logic             validReg, validNext;
    logic             doneReg, doneNext;
    logic [CNT_W-1:0] countReg, countNext;
    logic [PC_W-1:0]  fetchAddr;
    logic             isHalt;

    assign isHalt = (imem_rdata == HALT_CODE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
            pcReg    <= '0;
            validReg <= 1'b0;
            doneReg  <= 1'b0;
            countReg <= '0;
        end else begin
            stateReg <= stateNext;
            pcReg    <= pcNext;
            validReg <= validNext;
            doneReg  <= doneNext;
            countReg <= countNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        pcNext    = pcReg;
        validNext = validReg;
        doneNext  = doneReg;
        countNext = countReg;
        fetchAddr = START_ADDR;

        case (stateReg)
            IDLE, HALTED: begin
                // Outside RUN the memory is primed with START_PC so a start
                // lands the first instruction on instr with no extra cycle.
                if (start) begin
                    stateNext = RUN;
                    pcNext    = START_ADDR;
                    validNext = 1'b1;
                    doneNext  = 1'b0;
                    countNext = '0;
                end
            end
            RUN: begin
                if (stall) begin
                    fetchAddr = pcReg;
                end else if (branch_taken) begin
                    fetchAddr = branch_target;
                end else begin
                    fetchAddr = pcReg + PC_W'(1);
                end

                if (!stall) begin
                    if (isHalt) begin
                        stateNext = HALTED;
                        validNext = 1'b0;
                        doneNext  = 1'b1;
                    end else begin
                        pcNext = fetchAddr;
                        if (countReg != '1) begin
                            countNext = countReg + CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                validNext = 1'b0;
                doneNext  = 1'b0;
            end
        endcase
    end

    assign imem_addr   = fetchAddr;
    assign instr       = imem_rdata;
    assign opcode      = imem_rdata[INSTR_W-1:INSTR_W-3];
    assign last_bit    = imem_rdata[0];
    assign instr_valid = validReg;
    assign pc          = pcReg;
    assign done        = doneReg;
    assign instr_count = countReg;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed program runs pinned by literal values, then
// random start/stall/branch/reset traffic checked every cycle against a program-level model.
module tb_instr_fetch;

    localparam int PC_W  = 10;
    localparam int IW    = 9;
    localparam int CNT_W = 4;
    localparam logic [IW-1:0] HALT = 9'h1FF;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             stall = 1'b0;
    logic             branchTaken = 1'b0;
    logic [PC_W-1:0]  branchTarget = '0;
    logic [PC_W-1:0]  imemAddr;
    logic [IW-1:0]    imemRdata = '0;
    logic [IW-1:0]    instr;
    logic [2:0]       opcode;
    logic             lastBit;
    logic             instrValid;
    logic [PC_W-1:0]  pc;
    logic             done;
    logic [CNT_W-1:0] instrCount;

    logic [IW-1:0] mem [1024];

    int assertions = 0;
    int failures   = 0;

    // Program-level model: running/halted flags, PC of the live instruction, retire count
    bit               mRun  = 1'b0;
    bit               mHalt = 1'b0;
    logic [PC_W-1:0]  mPc   = '0;
    logic [CNT_W-1:0] mCnt  = '0;

    instr_fetch #(
        .PC_W(PC_W), .INSTR_W(IW), .START_PC(0), .HALT_CODE(HALT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_taken(branchTaken), .branch_target(branchTarget),
        .imem_addr(imemAddr), .imem_rdata(imemRdata),
        .instr(instr), .opcode(opcode), .last_bit(lastBit),
        .instr_valid(instrValid), .pc(pc), .done(done), .instr_count(instrCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imemRdata <= mem[imemAddr];

    task automatic chk(input string name, input int act, input int exp);
        assertions++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mRun  <= 1'b0;
            mHalt <= 1'b0;
            mPc   <= '0;
            mCnt  <= '0;
        end else if (!mRun) begin
            if (start) begin
                mRun  <= 1'b1;
                mHalt <= 1'b0;
                mPc   <= '0;
                mCnt  <= '0;
                $display("start run");
            end
        end else if (!stall) begin
            if (mem[mPc] == HALT) begin
                mRun  <= 1'b0;
                mHalt <= 1'b1;
                $display("halt at pc=%03h count=%0d", mPc, mCnt);
            end else begin
                $display("retire pc=%03h instr=%03h count=%0d", mPc, mem[mPc], mCnt);
                mCnt <= (int'(mCnt) == (1 << CNT_W) - 1) ? mCnt : mCnt + 1'b1;
                mPc  <= branchTaken ? branchTarget : mPc + 1'b1;
            end
        end
    end

    // Compare process: registered outputs from the last edge, imem_addr from current inputs
    always @(negedge clk) begin
        logic [PC_W-1:0] expAddr;
        logic [IW-1:0]   expInstr;
        if (!mRun)             expAddr = '0;
        else if (stall)        expAddr = mPc;
        else if (branchTaken)  expAddr = branchTarget;
        else                   expAddr = mPc + 1'b1;
        expInstr = mem[mPc];
        chk("imem_addr", int'(imemAddr), int'(expAddr));
        chk("instr_valid", int'(instrValid), int'(mRun));
        chk("done", int'(done), int'(mHalt));
        chk("pc", int'(pc), int'(mPc));
        chk("instr_count", int'(instrCount), int'(mCnt));
        if (mRun) begin
            chk("instr", int'(instr), int'(expInstr));
            chk("opcode", int'(opcode), int'(expInstr[8:6]));
            chk("last_bit", int'(lastBit), int'(expInstr[0]));
        end
    end

    task automatic step(input logic s, input logic st, input logic b, input logic [PC_W-1:0] t);
        start = s; stall = st; branchTaken = b; branchTarget = t;
        @(posedge clk);
        #2;
        start = 1'b0; stall = 1'b0; branchTaken = 1'b0;
    endtask

    task automatic lit(input int expPc, input int expInstr, input int expValid,
                       input int expDone, input int expCnt);
        chk("lit_pc", int'(pc), expPc);
        chk("lit_valid", int'(instrValid), expValid);
        chk("lit_done", int'(done), expDone);
        chk("lit_count", int'(instrCount), expCnt);
        if (expValid != 0) chk("lit_instr", int'(instr), expInstr);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0] = 9'h041; mem[1] = 9'h081; mem[2] = 9'h0C0; mem[3] = HALT;
        mem[10'h20] = 9'h155; mem[10'h30] = HALT;
        mem[10'h3FE] = 9'h0AA; mem[10'h3FF] = 9'h055;

        repeat (3) step(0, 0, 0, 0);
        lit(0, 0, 0, 0, 0);
        reset = 1'b0;
        step(0, 0, 0, 0);

        // Run 1: straight line into the halt at 3
        step(1, 0, 0, 0);   lit(0, 9'h041, 1, 0, 0);
        step(0, 0, 0, 0);   lit(1, 9'h081, 1, 0, 1);
        step(0, 0, 0, 0);   lit(2, 9'h0C0, 1, 0, 2);
        step(0, 0, 0, 0);   lit(3, HALT, 1, 0, 3);
        step(0, 0, 0, 0);   lit(3, 0, 0, 1, 3);
        step(0, 0, 0, 0);   lit(3, 0, 0, 1, 3);

        // Run 2: stall, branch, stalled branch, halt beating a branch
        step(1, 0, 0, 0);   lit(0, 9'h041, 1, 0, 0);
        step(0, 0, 0, 0);   lit(1, 9'h081, 1, 0, 1);
        repeat (3) begin
            step(0, 1, 0, 0); lit(1, 9'h081, 1, 0, 1);
        end
        step(0, 0, 0, 0);         lit(2, 9'h0C0, 1, 0, 2);
        step(0, 0, 1, 10'h20);    lit(10'h20, 9'h155, 1, 0, 3);
        step(0, 1, 1, 10'h30);    lit(10'h20, 9'h155, 1, 0, 3);
        step(0, 1, 1, 10'h30);    lit(10'h20, 9'h155, 1, 0, 3);
        step(0, 0, 1, 10'h30);    lit(10'h30, HALT, 1, 0, 4);
        step(1, 0, 1, 10'h05);    lit(10'h30, 0, 0, 1, 4);

        // Run 3: PC wrap from 0x3FF, then asynchronous reset mid-run
        step(1, 0, 0, 0);         lit(0, 9'h041, 1, 0, 0);
        step(0, 0, 1, 10'h3FE);   lit(10'h3FE, 9'h0AA, 1, 0, 1);
        step(0, 0, 0, 0);         lit(10'h3FF, 9'h055, 1, 0, 2);
        step(0, 0, 0, 0);         lit(0, 9'h041, 1, 0, 3);
        step(0, 0, 0, 0);         lit(1, 9'h081, 1, 0, 4);
        step(0, 0, 0, 0);         lit(2, 9'h0C0, 1, 0, 5);
        stall = 1'b1;
        reset = 1'b1;
        #1;
        lit(0, 0, 0, 0, 0);
        chk("lit_reset_addr", int'(imemAddr), 0);
        stall = 1'b0;
        step(1, 0, 0, 0);         lit(0, 0, 0, 0, 0);
        reset = 1'b0;
        step(1, 0, 0, 0);         lit(0, 9'h041, 1, 0, 0);
        step(0, 0, 0, 0);         lit(1, 9'h081, 1, 0, 1);

        // Random phase on a fresh program, loaded while held in reset
        reset = 1'b1;
        step(0, 0, 0, 0);
        for (int i = 0; i < 1024; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? HALT : IW'($urandom_range(0, 510));
        reset = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                step(0, 0, 0, 0);
                reset = 1'b0;
            end
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, PC_W'($urandom_range(0, 1023)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
